lcd_text_i2c: RTL and testbench
===============================

LCD_TEXT_I2C -- requirements
Module: lcd_text_i2c

Interface
REQ-001 Parameter ROWS, default 2: display rows; legal 1, 2, 4.
REQ-002 Parameter COLS, default 16: characters per row; legal 8..20.
REQ-003 Parameter CHANNELS, default 2: selectable text sources; legal 1..4.
REQ-004 Parameter POR_CYCLES, default 50000: power-up wait in clk cycles before the first command.
REQ-005 clk  in  1  single system clock; all logic on its negedge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 text  in  CHANNELS*ROWS*COLS*8  character codes; channel c, row r, column k at byte index (c*ROWS+r)*COLS+k.
REQ-008 ch_sel  in  max(1,$clog2(CHANNELS))  channel to display.
REQ-009 backlight  in  1  sets expander bit 3 in every byte sent.
REQ-010 refresh_en  in  1  enables continuous frame refresh after init.
REQ-011 tx_data  out  8  PCF8574 byte to the I2C master.
REQ-012 tx_valid  out  1  tx_data valid.
REQ-013 tx_ready  in  1  master accepts the byte on a cycle where tx_valid and tx_ready are both high.
REQ-014 tx_last  out  1  accepted byte ends the I2C transaction; the master issues STOP.
REQ-015 init_done  out  1  high once the init sequence has completed.
REQ-016 frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.

Function
REQ-017 Each LCD byte B SHALL be sent as four expander bytes: {B[7:4],BL,1,0,RS}, {B[7:4],BL,0,0,RS}, {B[3:0],BL,1,0,RS}, {B[3:0],BL,0,0,RS}; RS=0 for commands, RS=1 for data.
REQ-018 States: POR_WAIT, INIT, IDLE, ROW_ADDR, ROW_CHAR, FRAME_END.
REQ-019 POR_WAIT SHALL count POR_CYCLES, then enter INIT.
REQ-020 INIT SHALL send commands 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01 as one transaction; tx_last is set on the final byte.
REQ-021 After INIT, init_done SHALL rise and the FSM SHALL enter IDLE.
REQ-022 IDLE→ROW_ADDR when refresh_en=1; ch_sel SHALL be latched at this transition and held for the whole frame.
REQ-023 ROW_ADDR SHALL send command 0x80|offset with row offsets 0x00, 0x40, 0x14, 0x54 for rows 0..3.
REQ-024 ROW_CHAR SHALL send COLS data bytes for column 0..COLS-1.
REQ-025 Each row SHALL be one transaction: tx_last is set on the 4th expander byte of column COLS-1.
REQ-026 After the last row: FRAME_END, frame_done pulses, then IDLE.
REQ-027 tx_valid SHALL stay high and tx_data/tx_last stable until accepted; the next byte is presented on the cycle after acceptance (one byte per two cycles at full rate).
REQ-028 backlight and text SHALL be sampled when each expander byte is formed, so a change mid-frame shows up on the next byte formed.
REQ-029 Deasserting refresh_en mid-frame SHALL complete the current frame; it has no effect on INIT.
REQ-030 If ch_sel ≥ CHANNELS, the channel used SHALL be CHANNELS-1.

Reset
REQ-031 On rst: state POR_WAIT, counters 0, tx_valid=0, tx_last=0, tx_data=0x00, init_done=0, frame_done=0; applies immediately, including mid-transaction.
REQ-032 After rst is released, the full POR wait and INIT SHALL be repeated.

Structure
REQ-033 Package lcd_pkg SHALL hold: the state enum, expander bit positions (RS=0, RW=1, EN=2, BL=3), the INIT command ROM, and the row offset table.
REQ-034 Sub-module lcd_nibble_ser SHALL hold the byte→4-expander-byte serializer and the valid/ready handshake; the top-level FSM feeds it {byte, rs, last}.

Verification
REQ-035 rst released, POR_CYCLES=10, tx_ready=1: first byte 0x3C appears after 10 cycles; INIT sends 24 bytes; tx_last on the 24th (0x18); then init_done=1.
REQ-036 ROWS=2, COLS=16, refresh_en=1, ch0 row0 text "A" (0x41), backlight=1: row 0 starts 0x8C,0x88,0x0C,0x08, then 0x4D,0x49,0x1D,0x19; tx_last on byte 68.
REQ-037 tx_ready held low for 5 cycles mid-row: tx_data and tx_valid stay stable; no byte is lost or duplicated.
REQ-038 ch_sel changes 0→1 mid-frame: the frame completes from channel 0; the next frame uses channel 1; frame_done pulses exactly once per frame.
REQ-039 rst asserted while tx_valid=1 mid-row: tx_valid=0 and init_done=0 on the same edge; after release, POR and INIT repeat.
REQ-040 ROWS=4, COLS=20: row address commands 0x80, 0xC0, 0x94, 0xD4 are sent in order.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD-over-I2C-expander text engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lcd_pkg;

    // Controller states; one frame walks ROW_ADDR/ROW_CHAR once per row.
    typedef enum logic [2:0] {
        POR_WAIT,
        INIT,
        IDLE,
        ROW_ADDR,
        ROW_CHAR,
        FRAME_END
    } state_t;

    // PCF8574 bit positions driving the HD44780 control lines.
    localparam int RS_BIT = 0;
    localparam int RW_BIT = 1;
    localparam int EN_BIT = 2;
    localparam int BL_BIT = 3;

    // 4-bit mode bring-up: 0x33/0x32 force nibble mode, then function set,
    // display on, entry mode, clear. Entry 0 is sent first.
    localparam int INIT_LEN = 6;
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM =
        {8'h01, 8'h06, 8'h0C, 8'h28, 8'h32, 8'h33};

    // DDRAM start address of each display row (rows 0..3).
    localparam logic [3:0][7:0] ROW_OFS = {8'h54, 8'h14, 8'h40, 8'h00};

    // Build one expander byte: data nibble on the upper half, control below.
    function automatic logic [7:0] exp_byte(input logic [3:0] nib,
                                            input logic       bl,
                                            input logic       en,
                                            input logic       rs);
        logic [7:0] b;
        b         = {nib, 4'h0};
        b[BL_BIT] = bl;
        b[EN_BIT] = en;
        b[RW_BIT] = 1'b0;
        b[RS_BIT] = rs;
        return b;
    endfunction

endpackage

// File: rtl/lcd_text_i2c_if.sv
// Byte stream from the LCD engine to the I2C master (one byte per beat).
// Latency: n/a (wires only).
// Backpressure: valid/ready; a byte transfers when tx_valid and tx_ready are high.
interface lcd_text_i2c_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    // Producer side (the LCD engine).
    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    // Consumer side (the I2C master).
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/lcd_nibble_ser.sv
// Splits each LCD byte into four expander bytes (hi nibble EN=1/0, lo nibble EN=1/0).
// Latency: first expander byte valid one cycle after in_vld; next one the cycle after each accept.
// Backpressure: holds tx_data/tx_last with tx_valid high until tx_ready; in_done pulses on the 4th accept.
module lcd_nibble_ser
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_vld,
    input  logic [7:0] in_byte,
    input  logic       in_rs,
    input  logic       in_last,
    input  logic       backlight,
    output logic       in_done,
    lcd_text_i2c_if.master tx
);

    logic [1:0] phase;
    logic       accept;
    logic [3:0] nibble;

    assign accept  = tx.tx_valid & tx.tx_ready;
    // The feeder advances on the same edge that the 4th expander byte is taken.
    assign in_done = accept & (phase == 2'd3);
    // Phases 0/1 carry the high nibble, 2/3 the low nibble.
    assign nibble  = phase[1] ? in_byte[3:0] : in_byte[7:4];

    // Present/hold/retire expander bytes; the byte and backlight are read at
    // the moment each expander byte is formed, so live changes show up next byte.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            phase       <= 2'd0;
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else if (accept) begin
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            phase       <= phase + 2'd1;
        end else if (!tx.tx_valid && in_vld) begin
            tx.tx_data  <= exp_byte(nibble, backlight, ~phase[0], in_rs);
            tx.tx_last  <= in_last & (phase == 2'd3);
            tx.tx_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/lcd_text_i2c.sv
// Drives an HD44780 LCD behind a PCF8574 expander: power-up wait, 4-bit init, then row-by-row text frames.
// Latency: first byte POR_CYCLES+1 cycles after reset release; one expander byte per two cycles at full rate.
// Backpressure: stalls on tx_ready low with tx_data/tx_last held; nothing is dropped or repeated.
module lcd_text_i2c
    import lcd_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int CHANNELS   = 2,
    parameter int POR_CYCLES = 50000
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [CHANNELS*ROWS*COLS*8-1:0]            text,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
    input  logic                                       backlight,
    input  logic                                       refresh_en,
    lcd_text_i2c_if.master                             tx,
    output logic                                       init_done,
    output logic                                       frame_done
);

    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(COLS);

    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [31:0]   POR_LAST  = 32'(POR_CYCLES - 1);
    localparam logic [2:0]    INIT_LAST = 3'(INIT_LEN - 1);
    localparam logic [SW-1:0] CH_MAX    = SW'(CHANNELS - 1);

    state_t        state;
    logic [31:0]   por_cnt;
    logic [2:0]    init_idx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [SW-1:0] ch_lat;
    logic [SW-1:0] ch_eff;

    logic          ser_vld;
    logic [7:0]    ser_byte;
    logic          ser_rs;
    logic          ser_last;
    logic          ser_done;
    logic [7:0]    char_byte;
    int            pos;

    // Out-of-range selections fall back to the highest channel.
    assign ch_eff = (int'(ch_sel) >= CHANNELS) ? CH_MAX : ch_sel;

    // Character at the current frame position, read live from the text bus.
    always_comb begin
        pos       = 0;
        pos       = (int'(ch_lat) * ROWS + int'(row)) * COLS + int'(col);
        char_byte = text[pos*8 +: 8];
    end

    // LCD byte the serializer should currently be emitting, by state.
    always_comb begin
        ser_vld  = 1'b0;
        ser_byte = 8'h00;
        ser_rs   = 1'b0;
        ser_last = 1'b0;
        case (state)
            INIT: begin
                ser_vld  = 1'b1;
                ser_byte = INIT_ROM[init_idx];
                ser_last = (init_idx == INIT_LAST);
            end
            ROW_ADDR: begin
                ser_vld  = 1'b1;
                ser_byte = 8'h80 | ROW_OFS[2'(row)];
            end
            ROW_CHAR: begin
                ser_vld  = 1'b1;
                ser_byte = char_byte;
                ser_rs   = 1'b1;
                ser_last = (col == COL_LAST);
            end
            default: ;
        endcase
    end

    // Sequencer: power-up wait, init burst, then frames while refresh_en is set.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= POR_WAIT;
            por_cnt    <= 32'd0;
            init_idx   <= 3'd0;
            row        <= '0;
            col        <= '0;
            ch_lat     <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                POR_WAIT: begin
                    if (por_cnt == POR_LAST) begin
                        por_cnt <= 32'd0;
                        state   <= INIT;
                    end else begin
                        por_cnt <= por_cnt + 32'd1;
                    end
                end
                INIT: begin
                    if (ser_done) begin
                        if (init_idx == INIT_LAST) begin
                            init_idx  <= 3'd0;
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                        end
                    end
                end
                IDLE: begin
                    // Channel is frozen for the whole frame from here.
                    if (refresh_en) begin
                        ch_lat <= ch_eff;
                        row    <= '0;
                        col    <= '0;
                        state  <= ROW_ADDR;
                    end
                end
                ROW_ADDR: begin
                    if (ser_done) begin
                        col   <= '0;
                        state <= ROW_CHAR;
                    end
                end
                ROW_CHAR: begin
                    // refresh_en is not looked at here: a started frame always finishes.
                    if (ser_done) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row   <= '0;
                                state <= FRAME_END;
                            end else begin
                                row   <= row + 1'b1;
                                state <= ROW_ADDR;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                FRAME_END: begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= POR_WAIT;
            endcase
        end
    end

    lcd_nibble_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (ser_vld),
        .in_byte   (ser_byte),
        .in_rs     (ser_rs),
        .in_last   (ser_last),
        .backlight (backlight),
        .in_done   (ser_done),
        .tx        (tx)
    );

endmodule

// File: tb/tb_lcd_text_i2c.sv
// Directed bench for lcd_text_i2c: init sequence, text frames, stalls, channel switch, reset, 4x20 addressing.
// Expected expander bytes are queued when stimulus is set up and popped as the DUT hands bytes over.
// Inputs change 1 time unit after the falling (active) edge; outputs are observed on the rising edge.
module tb_lcd_text_i2c;

    localparam int ROWS     = 2;
    localparam int COLS     = 16;
    localparam int CHANNELS = 2;
    localparam int POR      = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;

    logic [CHANNELS*ROWS*COLS*8-1:0] text;
    logic [0:0] ch_sel;
    logic       backlight;
    logic       refresh_en;
    logic       init_done;
    logic       frame_done;

    logic [4*20*8-1:0] text4;
    logic [0:0] ch_sel4;
    logic       init_done4;
    logic       frame_done4;

    lcd_text_i2c_if tif();
    lcd_text_i2c_if t4();

    int checks = 0;
    int errors = 0;

    logic [8:0] sbq[$];
    logic [8:0] log_q[$];
    logic [7:0] log4[$];
    logic [8:0] got;
    logic [8:0] exp_e;
    bit         sb_en = 1'b0;
    bit         prev_fd = 1'b0;
    int         fd_cnt = 0;
    int         fd4 = 0;

    logic [7:0] init_cmds [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};
    logic [7:0] row0_head [8] = '{8'h8C, 8'h88, 8'h0C, 8'h08, 8'h4D, 8'h49, 8'h1D, 8'h19};
    logic [7:0] addr4     [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};

    always #5 clk = ~clk;

    lcd_text_i2c #(.ROWS(ROWS), .COLS(COLS), .CHANNELS(CHANNELS), .POR_CYCLES(POR)) dut (
        .clk(clk), .rst(rst), .text(text), .ch_sel(ch_sel), .backlight(backlight),
        .refresh_en(refresh_en), .tx(tif), .init_done(init_done), .frame_done(frame_done)
    );

    lcd_text_i2c #(.ROWS(4), .COLS(20), .CHANNELS(1), .POR_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst4), .text(text4), .ch_sel(ch_sel4), .backlight(1'b1),
        .refresh_en(1'b1), .tx(t4), .init_done(init_done4), .frame_done(frame_done4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] char_of(input int c, input int r, input int k);
        if (c == 0 && r == 0 && k == 0) return 8'h41;
        return 8'(48 + 32*c + 16*r + k);
    endfunction

    // Four expander bytes per LCD byte, last flag only on the fourth.
    task automatic push_lcd(input logic [7:0] b, input logic rs, input logic last);
        sbq.push_back({b[7:4], backlight, 1'b1, 1'b0, rs, 1'b0});
        sbq.push_back({b[7:4], backlight, 1'b0, 1'b0, rs, 1'b0});
        sbq.push_back({b[3:0], backlight, 1'b1, 1'b0, rs, 1'b0});
        sbq.push_back({b[3:0], backlight, 1'b0, 1'b0, rs, last});
    endtask

    task automatic push_frame(input int c);
        for (int r = 0; r < ROWS; r++) begin
            push_lcd((r == 0) ? 8'h80 : 8'hC0, 1'b0, 1'b0);
            for (int k = 0; k < COLS; k++)
                push_lcd(char_of(c, r, k), 1'b1, k == COLS - 1);
        end
    endtask

    // Entered with rst high: checks reset outputs, releases, checks POR wait and INIT.
    task automatic por_init();
        int base;
        int n;
        step(2);
        chk("rst_tx_valid", 32'(tif.tx_valid), 0);
        chk("rst_tx_last", 32'(tif.tx_last), 0);
        chk("rst_tx_data", 32'(tif.tx_data), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        sbq.delete();
        for (int i = 0; i < 6; i++) push_lcd(init_cmds[i], 1'b0, i == 5);
        sb_en = 1'b1;
        base = log_q.size();
        rst = 1'b0;
        for (int i = 0; i < POR; i++) begin
            step(1);
            chk("por_quiet", 32'(tif.tx_valid), 0);
        end
        step(1);
        chk("first_valid", 32'(tif.tx_valid), 1);
        chk("first_byte", 32'(tif.tx_data), 32'h3C);
        n = 0;
        while (!init_done && n < 200) begin step(1); n++; end
        chk("init_done", 32'(init_done), 1);
        chk("init_count", 32'(log_q.size() - base), 24);
        chk("init_last24", (log_q.size() >= base + 24) ? 32'(log_q[base+23][0]) : 32'h0, 1);
        chk("init_sb_empty", 32'(sbq.size()), 0);
    endtask

    // Main DUT monitor: bytes are taken on the next falling edge when valid & ready now.
    always @(posedge clk) begin
        if (!rst) begin
            if (tif.tx_valid && tif.tx_ready) begin
                got = {tif.tx_data, tif.tx_last};
                log_q.push_back(got);
                if (sb_en) begin
                    checks++;
                    assert (sbq.size() > 0) else begin
                        errors++;
                        $error("FAIL sb_extra: observed 0x%0h expected no byte", got);
                    end
                    if (sbq.size() > 0) begin
                        exp_e = sbq.pop_front();
                        chk("sb_byte", 32'(got), 32'(exp_e));
                    end
                end
            end
            if (frame_done) begin
                fd_cnt++;
                chk("frame_done_width", 32'(prev_fd), 0);
            end
            prev_fd = frame_done;
        end
    end

    // 4x20 DUT: log every byte of the first init plus frame.
    always @(posedge clk) begin
        if (!rst4) begin
            if (t4.tx_valid && t4.tx_ready && fd4 == 0) log4.push_back(t4.tx_data);
            if (frame_done4) fd4++;
        end
    end

    initial begin
        int n;
        int base1;
        int base2;
        int held;
        int lpos;
        logic [7:0] snap;
        logic [7:0] cmds[$];

        tif.tx_ready = 1'b1;
        t4.tx_ready  = 1'b1;
        backlight    = 1'b1;
        refresh_en   = 1'b0;
        ch_sel       = 1'b0;
        ch_sel4      = 1'b0;
        text4        = {80{8'h20}};
        text         = '0;
        for (int c = 0; c < CHANNELS; c++)
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < COLS; k++)
                    text[((c*ROWS + r)*COLS + k)*8 +: 8] = char_of(c, r, k);

        rst = 1'b1;
        step(1);
        rst4 = 1'b0;
        por_init();

        // Idle with refresh off: nothing leaves the block.
        step(20);
        chk("idle_no_tx", 32'(tif.tx_valid), 0);

        // Two frames: ch0 then ch1 (ch_sel flips during frame 1).
        base1 = log_q.size();
        push_frame(0);
        push_frame(1);
        refresh_en = 1'b1;
        n = 0;
        while (log_q.size() < base1 + 30 && n < 500) begin step(1); n++; end
        n = 0;
        while (!tif.tx_valid && n < 10) begin step(1); n++; end
        chk("stall_start_valid", 32'(tif.tx_valid), 1);
        tif.tx_ready = 1'b0;
        snap = tif.tx_data;
        held = log_q.size();
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_valid", 32'(tif.tx_valid), 1);
            chk("stall_data", 32'(tif.tx_data), 32'(snap));
        end
        chk("stall_no_accept", 32'(log_q.size()), 32'(held));
        tif.tx_ready = 1'b1;
        ch_sel = 1'b1;

        n = 0;
        while (fd_cnt < 1 && n < 1000) begin step(1); n++; end
        chk("frame1_pulses", 32'(fd_cnt), 1);
        for (int i = 0; i < 8; i++)
            chk("row0_head", (log_q.size() > base1 + i) ? 32'(log_q[base1+i][8:1]) : 32'hFFFF,
                32'(row0_head[i]));
        lpos = -1;
        for (int i = base1; i < log_q.size(); i++)
            if (log_q[i][0]) begin lpos = i - base1; break; end
        chk("row0_last_pos", 32'(lpos + 1), 68);

        // Drop refresh_en mid frame 2: it must still finish, then stop.
        n = 0;
        while (log_q.size() < base1 + 136 + 40 && n < 1000) begin step(1); n++; end
        refresh_en = 1'b0;
        n = 0;
        while (fd_cnt < 2 && n < 1000) begin step(1); n++; end
        step(40);
        chk("idle_after_frame2", 32'(tif.tx_valid), 0);
        chk("frames_total", 32'(fd_cnt), 2);
        chk("sb_drained", 32'(sbq.size()), 0);

        // Reset in the middle of a row.
        sb_en = 1'b0;
        base2 = log_q.size();
        refresh_en = 1'b1;
        n = 0;
        while (log_q.size() < base2 + 20 && n < 500) begin step(1); n++; end
        n = 0;
        while (!tif.tx_valid && n < 10) begin step(1); n++; end
        chk("pre_rst_valid", 32'(tif.tx_valid), 1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(tif.tx_valid), 0);
        chk("rst_async_init_done", 32'(init_done), 0);
        refresh_en = 1'b0;
        por_init();
        step(30);
        chk("idle_after_reinit", 32'(tif.tx_valid), 0);

        // 4x20 instance: row address commands in order.
        n = 0;
        while (fd4 < 1 && n < 2000) begin step(1); n++; end
        chk("dut4_frame_seen", 32'(fd4 > 0), 1);
        chk("dut4_byte_count", 32'(log4.size()), 360);
        for (int i = 6; i < log4.size() / 4; i++)
            if (!log4[4*i][0]) cmds.push_back({log4[4*i][7:4], log4[4*i+2][7:4]});
        chk("dut4_addr_count", 32'(cmds.size()), 4);
        for (int j = 0; j < 4; j++)
            chk("dut4_row_addr", (cmds.size() > j) ? 32'(cmds[j]) : 32'hFFFF, 32'(addr4[j]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
